// File: rtl/image_pkg.sv
// Shared types and constants for the binary-image window scanner: size codes,
// controller states, tap geometry and filter select codes.
package image_pkg;

    typedef enum logic [1:0] {
        SIZE_4X4     = 2'd0,
        SIZE_8X8     = 2'd1,
        SIZE_16X16   = 2'd2,
        SIZE_ILLEGAL = 2'd3
    } size_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_PRESENT,
        ST_DONE
    } state_e;

    localparam int unsigned TAPS     = 9;
    localparam logic [3:0]  LAST_TAP = 4'(TAPS - 1);

    localparam logic [1:0] FILT_SOBEL_X   = 2'd0;
    localparam logic [1:0] FILT_SOBEL_Y   = 2'd1;
    localparam logic [1:0] FILT_SOBEL_MAG = 2'd2;
    localparam logic [1:0] FILT_PASS      = 2'd3;

    function automatic logic [4:0] image_dim(input logic [1:0] code);
        case (size_code_e'(code))
            SIZE_8X8:   return 5'd8;
            SIZE_16X16: return 5'd16;
            default:    return 5'd4;
        endcase
    endfunction

    // Tap k sits at (k/3, k%3) inside the 3x3 window.
    function automatic logic [1:0] tap_row_off(input logic [3:0] tap);
        case (tap)
            4'd0, 4'd1, 4'd2: return 2'd0;
            4'd3, 4'd4, 4'd5: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] tap_col_off(input logic [3:0] tap);
        case (tap)
            4'd0, 4'd3, 4'd6: return 2'd0;
            4'd1, 4'd4, 4'd7: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/tap_addr_calc.sv
// Combinational row-major address of one window tap: (row+dr)*n + (col+dc).
module tap_addr_calc
    import image_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned COORD_W = 4
) (
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] col,
    input  logic [3:0]         tap,
    input  logic [ADDR_W-1:0]  n,
    output logic [ADDR_W-1:0]  addr
);

    logic [ADDR_W-1:0] row_abs;
    logic [ADDR_W-1:0] col_abs;

    always_comb begin
        row_abs = ADDR_W'(row) + ADDR_W'(tap_row_off(tap));
        col_abs = ADDR_W'(col) + ADDR_W'(tap_col_off(tap));
        addr    = row_abs * n + col_abs;
    end

endmodule

// File: rtl/sobel_window_sequencer.sv
// Scans every 3x3 window of an NxN 1-bit image in pixel memory, assembles the
// nine taps and hands each window to the filter core over valid/ready.
module sobel_window_sequencer
    import image_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned COORD_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         size,
    input  logic [1:0]         filter,
    input  logic               pixel_in,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  pixel_addr,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [8:0]         window,
    output logic [COORD_W-1:0] out_row,
    output logic [COORD_W-1:0] out_col,
    output logic [1:0]         filter_sel,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_e             state_q, state_d;
    logic [3:0]         k_q, k_d;
    logic [COORD_W-1:0] r_q, r_d;
    logic [COORD_W-1:0] c_q, c_d;
    logic [1:0]         size_q, size_d;
    logic [1:0]         filter_q, filter_d;
    logic [8:0]         window_q, window_d;
    logic               err_q, err_d;

    logic [4:0]         n_val;
    logic [ADDR_W-1:0]  n_ext;
    logic [COORD_W-1:0] lim;
    logic [ADDR_W-1:0]  tap_addr;

    always_comb begin
        n_val = image_dim(size_q);
        n_ext = ADDR_W'(n_val);
        lim   = COORD_W'(n_val - 5'd3);
    end

    tap_addr_calc #(
        .ADDR_W  (ADDR_W),
        .COORD_W (COORD_W)
    ) u_tap_addr (
        .row  (r_q),
        .col  (c_q),
        .tap  (k_q),
        .n    (n_ext),
        .addr (tap_addr)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        r_d      = r_q;
        c_d      = c_q;
        size_d   = size_q;
        filter_d = filter_q;
        window_d = window_q;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (size_code_e'(size) == SIZE_ILLEGAL) begin
                        err_d = 1'b1;
                    end else begin
                        size_d   = size;
                        filter_d = filter;
                        r_d      = '0;
                        c_d      = '0;
                        k_d      = '0;
                        state_d  = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                // Read data trails the address by one cycle, so tap k-1 lands now.
                if (k_q != 4'd0) begin
                    window_d[k_q - 4'd1] = pixel_in;
                end
                if (k_q == LAST_TAP) begin
                    k_d     = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            ST_DRAIN: begin
                window_d[LAST_TAP] = pixel_in;
                state_d            = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (win_ready) begin
                    if (c_q == lim) begin
                        c_d = '0;
                        if (r_q == lim) begin
                            state_d = ST_DONE;
                        end else begin
                            r_d     = r_q + 1'b1;
                            state_d = ST_FETCH;
                        end
                    end else begin
                        c_d     = c_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            size_q   <= '0;
            filter_q <= '0;
            window_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            r_q      <= r_d;
            c_q      <= c_d;
            size_q   <= size_d;
            filter_q <= filter_d;
            window_q <= window_d;
            err_q    <= err_d;
        end
    end

    // Strobes decode straight from the state register so reset clears them at once.
    always_comb begin
        rd_en      = (state_q == ST_FETCH);
        pixel_addr = rd_en ? tap_addr : '0;
        win_valid  = (state_q == ST_PRESENT);
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        err        = err_q;
        window     = window_q;
        out_row    = r_q;
        out_col    = c_q;
        filter_sel = filter_q;
    end

endmodule
